rr_ex_stage_reg: RTL and testbench
==================================

Name: rr_ex_stage_reg

Overview:
- Pipeline register between the register-read (RR) stage and the execute (EX) stage of the MIPS pipeline.
- Latches decoded fields, operands and control from RR, and presents rs_rr_ex, rt_rr_ex, dstn_rr_ex and control to EX and to the forwarding unit.
- Detects load-use hazards against the instruction currently in EX. On a hazard it stalls RR/IF and inserts a bubble.
- Also handles downstream hold, branch flush and a saturating bubble counter.

Parameters:
- DATA_W, 32, operand data width
- REG_W, 5, register index width
- ALUOP_W, 4, ALU operation code width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_rr  in  1  RR stage holds a real instruction
- rs_rr, rt_rr, dstn_rr  in  REG_W  source/destination indices from RR
- uses_rs_rr, uses_rt_rr  in  1  instruction actually reads rs/rt
- rdata1_rr, rdata2_rr, imm_rr  in  DATA_W  register-file operands, sign-extended immediate
- RegWrite_rr, MemRead_rr, MemWrite_rr, MemtoReg_rr, ALUSrc_rr  in  1  control bits
- ALUop_rr  in  ALUOP_W  ALU operation
- hold_ex  in  1  EX/MEM cannot accept; freeze this register
- flush_ex  in  1  taken branch/jump resolved; squash instruction entering EX
- valid_rr_ex  out  1  EX holds a real instruction
- rs_rr_ex, rt_rr_ex, dstn_rr_ex  out  REG_W  registered indices
- rdata1_rr_ex, rdata2_rr_ex, imm_rr_ex  out  DATA_W  registered operands
- RegWrite_rr_ex, MemRead_rr_ex, MemWrite_rr_ex, MemtoReg_rr_ex, ALUSrc_rr_ex  out  1  registered control
- ALUop_rr_ex  out  ALUOP_W  registered ALU op
- stall_rr  out  1  combinational; upstream (PC, IF/RR) must hold this cycle
- bubble_cnt  out  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
- Reset, asynchronous on rst_n low:
  - All registered outputs are 0, which is a bubble: valid 0, all control 0, indices 0, data 0.
  - bubble_cnt is 0.
  - Reset mid-operation discards the in-flight instruction immediately, with no clock required.
- hazard (combinational) is 1 when all of the following hold:
  - valid_rr_ex and MemRead_rr_ex are both 1.
  - dstn_rr_ex != 0.
  - valid_rr is 1.
  - (uses_rs_rr and rs_rr == dstn_rr_ex) or (uses_rt_rr and rt_rr == dstn_rr_ex).
- stall_rr = (hazard or hold_ex) and not flush_ex.
- Register update on the rising edge of clk, first matching rule wins:
  1. flush_ex=1: load a bubble. flush_ex overrides hold_ex and hazard.
  2. hold_ex=1: all registered outputs keep their values. No bubble is inserted and bubble_cnt does not count.
  3. hazard=1: load a bubble. bubble_cnt increments by 1 and saturates at all-ones.
  4. Otherwise: capture all RR inputs.
     - If valid_rr=0, capture a bubble rather than the raw fields, so invalid slots never carry RegWrite or a nonzero dstn.
- Bubble definition:
  - valid, RegWrite, MemRead, MemWrite and MemtoReg are 0.
  - dstn, rs and rt are 0.
  - Data, imm, ALUop and ALUSrc are 0.
  - This guarantees the forwarding unit never matches a bubble.
- Latency: one cycle from RR inputs to EX outputs. A load-use hazard costs exactly one bubble.
  - The cycle after the bubble, the load is in MEM and hazard deasserts, so RR is captured normally.
- Back-to-back hazards each insert one bubble. A hazard re-evaluates every cycle.
- A hazard against $0 (dstn_rr_ex == 0) never stalls.

Decomposition:
- A shared package holds:
  - Width constants REG_W, DATA_W and ALUOP_W.
  - A packed typedef rr_ex_ctrl_t containing {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUop}.
  - The constant CTRL_BUBBLE (all zero).
- One natural sub-module, load_use_detect: the purely combinational hazard compare, reusable by a later branch-compare stage.
- The counter and registers remain in the top-level block.

Test Plan:
- Reset: assert rst_n=0 mid-stream with valid_rr_ex=1 -> all outputs 0 asynchronously before the next edge; bubble_cnt=0.
- Normal flow: valid_rr=1, rs=3, rt=4, dstn=5, rdata1=0x11, RegWrite=1 -> next edge rs_rr_ex=3, rt_rr_ex=4, dstn_rr_ex=5, rdata1_rr_ex=0x11, valid_rr_ex=1; stall_rr=0.
- Load-use: EX holds lw with dstn=8, MemRead=1; RR has rs=8 with uses_rs=1 ->
  - stall_rr=1 that cycle; next edge is a bubble (valid_rr_ex=0, dstn_rr_ex=0) and bubble_cnt=1.
  - Following edge captures the RR instruction with rs_rr_ex=8.
- No false stall: EX holds lw with dstn=8; RR has rt=8 but uses_rt=0, or lw dstn=0 -> stall_rr=0, normal capture, bubble_cnt unchanged.
- Hold vs flush:
  - hold_ex=1 for 3 cycles with changing RR inputs -> outputs frozen, stall_rr=1.
  - Then hold_ex=1 and flush_ex=1 together -> next edge is a bubble and stall_rr=0.
- Saturation: CNT_W=2 with 5 consecutive load-use hazards -> bubble_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/rr_ex_stage_reg_pkg.sv
// Shared widths and control/payload types for the RR->EX pipeline register.
package rr_ex_stage_reg_pkg;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;

  typedef struct packed {
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               ALUSrc;
    logic [ALUOP_W-1:0] ALUop;
  } rr_ex_ctrl_t;

  localparam rr_ex_ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dstn;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    rr_ex_ctrl_t       ctrl;
  } rr_ex_pay_t;

  // An all-zero slot never writes and never matches in forwarding.
  localparam rr_ex_pay_t PAY_BUBBLE = '{valid: 1'b0, rs: '0, rt: '0, dstn: '0,
                                        rdata1: '0, rdata2: '0, imm: '0,
                                        ctrl: CTRL_BUBBLE};
endpackage

// File: rtl/rr_ex_stage_reg_load_use_detect.sv
// Combinational load-use compare of an RR-stage consumer against a load in EX.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             valid_ex,
  input  logic             memread_ex,
  input  logic [REG_W-1:0] dstn_ex,
  input  logic             valid_rr,
  input  logic             uses_rs_rr,
  input  logic             uses_rt_rr,
  input  logic [REG_W-1:0] rs_rr,
  input  logic [REG_W-1:0] rt_rr,
  output logic             hazard
);
  logic load_in_ex;
  logic rs_hit;
  logic rt_hit;

  always_comb begin
    // $0 is never a real producer, so a load targeting it cannot stall.
    load_in_ex = valid_ex && memread_ex && (dstn_ex != '0);
    rs_hit     = uses_rs_rr && (rs_rr == dstn_ex);
    rt_hit     = uses_rt_rr && (rt_rr == dstn_ex);
    hazard     = load_in_ex && valid_rr && (rs_hit || rt_hit);
  end
endmodule

// File: rtl/rr_ex_stage_reg.sv
// RR->EX pipeline register with load-use bubble insertion, hold, flush and a
// saturating bubble counter.
module rr_ex_stage_reg
  import rr_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W  = rr_ex_stage_reg_pkg::DATA_W,
  parameter int REG_W   = rr_ex_stage_reg_pkg::REG_W,
  parameter int ALUOP_W = rr_ex_stage_reg_pkg::ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_rr,
  input  logic [REG_W-1:0]   rs_rr,
  input  logic [REG_W-1:0]   rt_rr,
  input  logic [REG_W-1:0]   dstn_rr,
  input  logic               uses_rs_rr,
  input  logic               uses_rt_rr,
  input  logic [DATA_W-1:0]  rdata1_rr,
  input  logic [DATA_W-1:0]  rdata2_rr,
  input  logic [DATA_W-1:0]  imm_rr,
  input  logic               RegWrite_rr,
  input  logic               MemRead_rr,
  input  logic               MemWrite_rr,
  input  logic               MemtoReg_rr,
  input  logic               ALUSrc_rr,
  input  logic [ALUOP_W-1:0] ALUop_rr,
  input  logic               hold_ex,
  input  logic               flush_ex,
  output logic               valid_rr_ex,
  output logic [REG_W-1:0]   rs_rr_ex,
  output logic [REG_W-1:0]   rt_rr_ex,
  output logic [REG_W-1:0]   dstn_rr_ex,
  output logic [DATA_W-1:0]  rdata1_rr_ex,
  output logic [DATA_W-1:0]  rdata2_rr_ex,
  output logic [DATA_W-1:0]  imm_rr_ex,
  output logic               RegWrite_rr_ex,
  output logic               MemRead_rr_ex,
  output logic               MemWrite_rr_ex,
  output logic               MemtoReg_rr_ex,
  output logic               ALUSrc_rr_ex,
  output logic [ALUOP_W-1:0] ALUop_rr_ex,
  output logic               stall_rr,
  output logic [CNT_W-1:0]   bubble_cnt
);
  rr_ex_pay_t       pay_d, pay_q, pay_in;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             hazard;

  load_use_detect #(.REG_W(REG_W)) u_lud (
    .valid_ex   (pay_q.valid),
    .memread_ex (pay_q.ctrl.MemRead),
    .dstn_ex    (pay_q.dstn),
    .valid_rr   (valid_rr),
    .uses_rs_rr (uses_rs_rr),
    .uses_rt_rr (uses_rt_rr),
    .rs_rr      (rs_rr),
    .rt_rr      (rt_rr),
    .hazard     (hazard)
  );

  always_comb begin
    pay_in.valid         = 1'b1;
    pay_in.rs            = rs_rr;
    pay_in.rt            = rt_rr;
    pay_in.dstn          = dstn_rr;
    pay_in.rdata1        = rdata1_rr;
    pay_in.rdata2        = rdata2_rr;
    pay_in.imm           = imm_rr;
    pay_in.ctrl.RegWrite = RegWrite_rr;
    pay_in.ctrl.MemRead  = MemRead_rr;
    pay_in.ctrl.MemWrite = MemWrite_rr;
    pay_in.ctrl.MemtoReg = MemtoReg_rr;
    pay_in.ctrl.ALUSrc   = ALUSrc_rr;
    pay_in.ctrl.ALUop    = ALUop_rr;
  end

  always_comb begin
    stall_rr = (hazard || hold_ex) && !flush_ex;
    pay_d    = pay_q;
    cnt_d    = cnt_q;
    if (flush_ex) begin
      pay_d = PAY_BUBBLE;
    end else if (hold_ex) begin
      pay_d = pay_q;
    end else if (hazard) begin
      pay_d = PAY_BUBBLE;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (valid_rr) begin
      pay_d = pay_in;
    end else begin
      // Invalid RR slots are scrubbed so they never carry RegWrite or a dstn.
      pay_d = PAY_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pay_q <= PAY_BUBBLE;
      cnt_q <= '0;
    end else begin
      pay_q <= pay_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    valid_rr_ex    = pay_q.valid;
    rs_rr_ex       = pay_q.rs;
    rt_rr_ex       = pay_q.rt;
    dstn_rr_ex     = pay_q.dstn;
    rdata1_rr_ex   = pay_q.rdata1;
    rdata2_rr_ex   = pay_q.rdata2;
    imm_rr_ex      = pay_q.imm;
    RegWrite_rr_ex = pay_q.ctrl.RegWrite;
    MemRead_rr_ex  = pay_q.ctrl.MemRead;
    MemWrite_rr_ex = pay_q.ctrl.MemWrite;
    MemtoReg_rr_ex = pay_q.ctrl.MemtoReg;
    ALUSrc_rr_ex   = pay_q.ctrl.ALUSrc;
    ALUop_rr_ex    = pay_q.ctrl.ALUop;
    bubble_cnt     = cnt_q;
  end
endmodule

// File: tb/tb_rr_ex_stage_reg.sv
// Directed bench for rr_ex_stage_reg: scoreboarded next-state model plus
// explicit spot checks; counter width reduced to 2 to reach saturation.
module tb_rr_ex_stage_reg;
  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, dstn;
    logic [31:0] d1, d2, imm;
    logic        rw, mr, mw, m2r, as;
    logic [3:0]  op;
    logic [1:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_rr, uses_rs_rr, uses_rt_rr;
  logic [4:0]  rs_rr, rt_rr, dstn_rr;
  logic [31:0] rdata1_rr, rdata2_rr, imm_rr;
  logic        RegWrite_rr, MemRead_rr, MemWrite_rr, MemtoReg_rr, ALUSrc_rr;
  logic [3:0]  ALUop_rr;
  logic        hold_ex, flush_ex;
  logic        valid_rr_ex;
  logic [4:0]  rs_rr_ex, rt_rr_ex, dstn_rr_ex;
  logic [31:0] rdata1_rr_ex, rdata2_rr_ex, imm_rr_ex;
  logic        RegWrite_rr_ex, MemRead_rr_ex, MemWrite_rr_ex, MemtoReg_rr_ex, ALUSrc_rr_ex;
  logic [3:0]  ALUop_rr_ex;
  logic        stall_rr;
  logic [1:0]  bubble_cnt;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t m;
  exp_t sbq[$];

  rr_ex_stage_reg #(.DATA_W(32), .REG_W(5), .ALUOP_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid_rr(valid_rr),
    .rs_rr(rs_rr), .rt_rr(rt_rr), .dstn_rr(dstn_rr),
    .uses_rs_rr(uses_rs_rr), .uses_rt_rr(uses_rt_rr),
    .rdata1_rr(rdata1_rr), .rdata2_rr(rdata2_rr), .imm_rr(imm_rr),
    .RegWrite_rr(RegWrite_rr), .MemRead_rr(MemRead_rr), .MemWrite_rr(MemWrite_rr),
    .MemtoReg_rr(MemtoReg_rr), .ALUSrc_rr(ALUSrc_rr), .ALUop_rr(ALUop_rr),
    .hold_ex(hold_ex), .flush_ex(flush_ex),
    .valid_rr_ex(valid_rr_ex), .rs_rr_ex(rs_rr_ex), .rt_rr_ex(rt_rr_ex),
    .dstn_rr_ex(dstn_rr_ex), .rdata1_rr_ex(rdata1_rr_ex), .rdata2_rr_ex(rdata2_rr_ex),
    .imm_rr_ex(imm_rr_ex), .RegWrite_rr_ex(RegWrite_rr_ex), .MemRead_rr_ex(MemRead_rr_ex),
    .MemWrite_rr_ex(MemWrite_rr_ex), .MemtoReg_rr_ex(MemtoReg_rr_ex),
    .ALUSrc_rr_ex(ALUSrc_rr_ex), .ALUop_rr_ex(ALUop_rr_ex),
    .stall_rr(stall_rr), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t observe();
    exp_t o;
    o.v = valid_rr_ex; o.rs = rs_rr_ex; o.rt = rt_rr_ex; o.dstn = dstn_rr_ex;
    o.d1 = rdata1_rr_ex; o.d2 = rdata2_rr_ex; o.imm = imm_rr_ex;
    o.rw = RegWrite_rr_ex; o.mr = MemRead_rr_ex; o.mw = MemWrite_rr_ex;
    o.m2r = MemtoReg_rr_ex; o.as = ALUSrc_rr_ex; o.op = ALUop_rr_ex;
    o.cnt = bubble_cnt;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t exp);
    exp_t o;
    o = observe();
    n_assert++;
    assert (o === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, exp);
    end
  endtask

  task automatic set_rr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dn, input logic urs, input logic urt,
                        input logic [31:0] d1, input logic rw, input logic mr);
    valid_rr = v; rs_rr = rs; rt_rr = rt; dstn_rr = dn;
    uses_rs_rr = urs; uses_rt_rr = urt;
    rdata1_rr = d1; rdata2_rr = d1 ^ 32'hA5A5_0F0F; imm_rr = {27'd0, rt};
    RegWrite_rr = rw; MemRead_rr = mr; MemWrite_rr = 1'b0;
    MemtoReg_rr = mr; ALUSrc_rr = mr; ALUop_rr = rs[3:0];
  endtask

  // Called just after an active edge with inputs already driven.
  task automatic step(input string tag);
    logic haz, exp_stall;
    exp_t nx;
    haz = m.v && m.mr && (m.dstn != 5'd0) && valid_rr &&
          ((uses_rs_rr && rs_rr == m.dstn) || (uses_rt_rr && rt_rr == m.dstn));
    exp_stall = (haz || hold_ex) && !flush_ex;
    #1;
    chk({tag, ".stall"}, 64'(stall_rr), 64'(exp_stall));
    nx = m;
    if (flush_ex) begin
      nx = '0; nx.cnt = m.cnt;
    end else if (hold_ex) begin
      nx = m;
    end else if (haz) begin
      nx = '0; nx.cnt = (m.cnt == 2'd3) ? 2'd3 : m.cnt + 2'd1;
    end else if (valid_rr) begin
      nx.v = 1'b1; nx.rs = rs_rr; nx.rt = rt_rr; nx.dstn = dstn_rr;
      nx.d1 = rdata1_rr; nx.d2 = rdata2_rr; nx.imm = imm_rr;
      nx.rw = RegWrite_rr; nx.mr = MemRead_rr; nx.mw = MemWrite_rr;
      nx.m2r = MemtoReg_rr; nx.as = ALUSrc_rr; nx.op = ALUop_rr;
    end else begin
      nx = '0; nx.cnt = m.cnt;
    end
    sbq.push_back(nx);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      n_assert++; n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      m = sbq.pop_front();
      chk_all({tag, ".regs"}, m);
    end
  endtask

  initial begin
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};
    rst_n = 1'b0; hold_ex = 1'b0; flush_ex = 1'b0;
    set_rr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    m = '0;
    #12;
    chk_all("reset", exp_t'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal capture
    set_rr(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 32'h11, 1'b1, 1'b0);
    step("normal");
    chk("normal.rs", 64'(rs_rr_ex), 64'd3);
    chk("normal.rt", 64'(rt_rr_ex), 64'd4);
    chk("normal.dstn", 64'(dstn_rr_ex), 64'd5);
    chk("normal.rdata1", 64'(rdata1_rr_ex), 64'h11);
    chk("normal.valid", 64'(valid_rr_ex), 64'd1);

    // Invalid slot with junk fields becomes a bubble
    set_rr(1'b0, 5'd6, 5'd7, 5'd7, 1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b0);
    step("invalid");
    chk("invalid.dstn", 64'(dstn_rr_ex), 64'd0);
    chk("invalid.regwrite", 64'(RegWrite_rr_ex), 64'd0);

    // Load-use on rs
    set_rr(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1);
    step("lw8");
    set_rr(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 32'h22, 1'b1, 1'b0);
    #1; chk("lu.stall", 64'(stall_rr), 64'd1);
    step("lu.bubble");
    chk("lu.valid", 64'(valid_rr_ex), 64'd0);
    chk("lu.dstn", 64'(dstn_rr_ex), 64'd0);
    chk("lu.cnt", 64'(bubble_cnt), 64'd1);
    step("lu.capture");
    chk("lu.rs", 64'(rs_rr_ex), 64'd8);

    // No false stall: rt matches but unused
    set_rr(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1);
    step("lw8b");
    set_rr(1'b1, 5'd2, 5'd8, 5'd11, 1'b1, 1'b0, 32'h33, 1'b1, 1'b0);
    #1; chk("nouse.stall", 64'(stall_rr), 64'd0);
    step("nouse");
    chk("nouse.cnt", 64'(bubble_cnt), 64'd1);
    chk("nouse.rt", 64'(rt_rr_ex), 64'd8);

    // No stall against a load to $0
    set_rr(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 32'h108, 1'b1, 1'b1);
    step("lw0");
    set_rr(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 32'h44, 1'b1, 1'b0);
    step("zero");
    chk("zero.cnt", 64'(bubble_cnt), 64'd1);

    // Hold for 3 cycles with changing RR inputs
    hold_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_rr(1'b1, 5'(13 + i), 5'(20 + i), 5'(25 + i), 1'b1, 1'b1, 32'(i * 7), 1'b1, 1'b0);
      step("hold");
      chk("hold.dstn", 64'(dstn_rr_ex), 64'd12);
    end
    flush_ex = 1'b1;
    step("holdflush");
    chk("flush.valid", 64'(valid_rr_ex), 64'd0);
    hold_ex = 1'b0; flush_ex = 1'b0;

    // Asynchronous reset mid-stream
    set_rr(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1);
    step("pre_reset");
    #3 rst_n = 1'b0;
    #1 chk_all("async_reset", exp_t'(0));
    m = '0; sbq.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Saturation: lw r8 depending on r8, repeated
    set_rr(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 32'h200, 1'b1, 1'b1);
    step("sat.first");
    for (int i = 0; i < 5; i++) begin
      step("sat.hazard");
      chk("sat.cnt", 64'(bubble_cnt), 64'(sat_exp[i]));
      step("sat.capture");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
